// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: RUN/SET controller for a BCD time-of-day clock.
//   clk, rst            : system clock, asynchronous active-high reset
//   tick_1ms, tick_1hz  : one-cycle timing strobes
//   btn_mode/next/up/down : debounced, clk-synchronous button levels
//   set_mode            : 1 while editing (SET), 0 while running (RUN)
//   run_en              : registered tick_1hz, only in RUN
//   field_idx, set_en   : selected field and its one-hot enable (SET only)
//   incr, decr          : single-cycle step pulses, with hold-to-repeat
//   blink               : blank strobe for the selected field while in SET
module clock_set_ctrl #(
  parameter int unsigned NUM_FIELDS   = 6,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned TIMEOUT      = 30,
  parameter int unsigned BLINK_HALF   = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1ms,
  input  logic                  tick_1hz,
  input  logic                  btn_mode,
  input  logic                  btn_next,
  input  logic                  btn_up,
  input  logic                  btn_down,
  output logic                  set_mode,
  output logic                  run_en,
  output logic [2:0]            field_idx,
  output logic [NUM_FIELDS-1:0] set_en,
  output logic                  incr,
  output logic                  decr,
  output logic                  blink
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_SET = 1'b1;

  localparam logic [1:0] RP_IDLE   = 2'd0;
  localparam logic [1:0] RP_DELAY  = 2'd1;
  localparam logic [1:0] RP_REPEAT = 2'd2;

  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);
  localparam int unsigned BW   = $clog2(BLINK_HALF + 1);

  localparam logic [RW-1:0] DLY_END  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_END = RW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT);
  localparam logic [BW-1:0] BLK_END  = BW'(BLINK_HALF - 1);
  localparam logic [2:0]    FLD_END  = 3'(NUM_FIELDS - 1);

  logic [0:0]            state, state_nx;
  logic                  armed;
  logic                  prev_mode, prev_next, prev_up, prev_down;
  logic                  mode_press, next_press, up_press, down_press;
  logic                  stay_set, up_ok, dn_ok, rep_hold, rep_fire, activity;
  logic [2:0]            field_nx;
  logic [NUM_FIELDS-1:0] set_en_nx;
  logic [1:0]            rep_state, rep_state_nx;
  logic [RW-1:0]         rep_cnt, rep_cnt_nx;
  logic                  rep_up, rep_up_nx;
  logic [TW-1:0]         tmo_cnt, tmo_cnt_nx;
  logic [BW-1:0]         blk_cnt, blk_cnt_nx;
  logic                  blink_nx, incr_nx, decr_nx, run_en_nx;

  assign set_mode = state[0];

  always_comb begin
    // armed is low for the first cycle after reset so held buttons are not presses
    mode_press = armed & btn_mode & ~prev_mode;
    next_press = armed & btn_next & ~prev_next;
    up_press   = armed & btn_up   & ~prev_up;
    down_press = armed & btn_down & ~prev_down;

    state_nx = state;
    if (mode_press)
      state_nx = (state == ST_RUN) ? ST_SET : ST_RUN;
    else if (state == ST_SET && tmo_cnt == TMO_END)
      state_nx = ST_RUN;

    // editing actions only apply when SET is both current and next state,
    // which is how a mode press suppresses simultaneous edits
    stay_set = (state == ST_SET) && (state_nx == ST_SET);

    field_nx = field_idx;
    if (!stay_set)
      field_nx = '0;
    else if (next_press)
      field_nx = (field_idx == FLD_END) ? '0 : field_idx + 3'd1;

    set_en_nx = '0;
    for (int unsigned i = 0; i < NUM_FIELDS; i++)
      set_en_nx[i] = (state_nx == ST_SET) && (field_nx == 3'(i));

    up_ok = stay_set & up_press & ~btn_down;
    dn_ok = stay_set & down_press & ~btn_up;

    rep_hold = stay_set & ~next_press &
               (rep_up ? (btn_up & ~btn_down) : (btn_down & ~btn_up));

    rep_state_nx = rep_state;
    rep_cnt_nx   = rep_cnt;
    rep_up_nx    = rep_up;
    rep_fire     = 1'b0;
    // a fresh press always restarts the delay, even if an old hold is active
    if ((up_ok | dn_ok) & ~next_press) begin
      rep_state_nx = RP_DELAY;
      rep_cnt_nx   = '0;
      rep_up_nx    = up_ok;
    end else if (rep_state != RP_IDLE && !rep_hold) begin
      rep_state_nx = RP_IDLE;
      rep_cnt_nx   = '0;
    end else if (rep_state == RP_DELAY && tick_1ms) begin
      if (rep_cnt == DLY_END) begin
        rep_fire     = 1'b1;
        rep_state_nx = RP_REPEAT;
        rep_cnt_nx   = '0;
      end else begin
        rep_cnt_nx = rep_cnt + 1'b1;
      end
    end else if (rep_state == RP_REPEAT && tick_1ms) begin
      if (rep_cnt == RATE_END) begin
        rep_fire   = 1'b1;
        rep_cnt_nx = '0;
      end else begin
        rep_cnt_nx = rep_cnt + 1'b1;
      end
    end

    incr_nx = up_ok | (rep_fire & rep_up);
    decr_nx = dn_ok | (rep_fire & ~rep_up);

    activity = mode_press | next_press | up_press | down_press | btn_up | btn_down;
    tmo_cnt_nx = tmo_cnt;
    if (!stay_set || activity)
      tmo_cnt_nx = '0;
    else if (tick_1hz && tmo_cnt != TMO_END)
      tmo_cnt_nx = tmo_cnt + 1'b1;

    blk_cnt_nx = blk_cnt;
    blink_nx   = blink;
    if (!stay_set) begin
      blk_cnt_nx = '0;
      blink_nx   = 1'b0;
    end else if (tick_1ms) begin
      if (blk_cnt == BLK_END) begin
        blk_cnt_nx = '0;
        blink_nx   = ~blink;
      end else begin
        blk_cnt_nx = blk_cnt + 1'b1;
      end
    end

    run_en_nx = tick_1hz & (state_nx == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      armed     <= 1'b0;
      prev_mode <= 1'b0;
      prev_next <= 1'b0;
      prev_up   <= 1'b0;
      prev_down <= 1'b0;
      field_idx <= '0;
      set_en    <= '0;
      rep_state <= RP_IDLE;
      rep_cnt   <= '0;
      rep_up    <= 1'b0;
      tmo_cnt   <= '0;
      blk_cnt   <= '0;
      blink     <= 1'b0;
      incr      <= 1'b0;
      decr      <= 1'b0;
      run_en    <= 1'b0;
    end else begin
      state     <= state_nx;
      armed     <= 1'b1;
      prev_mode <= btn_mode;
      prev_next <= btn_next;
      prev_up   <= btn_up;
      prev_down <= btn_down;
      field_idx <= field_nx;
      set_en    <= set_en_nx;
      rep_state <= rep_state_nx;
      rep_cnt   <= rep_cnt_nx;
      rep_up    <= rep_up_nx;
      tmo_cnt   <= tmo_cnt_nx;
      blk_cnt   <= blk_cnt_nx;
      blink     <= blink_nx;
      incr      <= incr_nx;
      decr      <= decr_nx;
      run_en    <= run_en_nx;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: vector table, directed corner
// sequences, then randomized buttons/ticks against a behavioural model.
module tb_clock_set_ctrl;

  localparam int NF  = 6;
  localparam int DLY = 500;
  localparam int RTE = 100;
  localparam int TMO = 30;
  localparam int BH  = 250;

  logic clk, rst, tick_1ms, tick_1hz;
  logic btn_mode, btn_next, btn_up, btn_down;
  logic set_mode, run_en, incr, decr, blink;
  logic [2:0] field_idx;
  logic [NF-1:0] set_en;

  int checks = 0;
  int errors = 0;

  clock_set_ctrl #(
    .NUM_FIELDS(NF), .REPEAT_DELAY(DLY), .REPEAT_RATE(RTE),
    .TIMEOUT(TMO), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .set_mode(set_mode), .run_en(run_en), .field_idx(field_idx), .set_en(set_en),
    .incr(incr), .decr(decr), .blink(blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic mode, next, up, down, t1ms, t1hz;
    logic exp_set;
    logic [2:0] exp_field;
    logic [5:0] exp_en;
    logic exp_incr, exp_decr, exp_run;
  } vec_t;

  vec_t vecs[14];

  // behavioural model state
  bit m_armed, m_pm, m_pn, m_pu, m_pd, m_set;
  int m_field, m_hold, m_ticks, m_secs, m_ms;
  logic e_set, e_incr, e_decr, e_run, e_blink;
  logic [2:0] e_field;
  logic [NF-1:0] e_en;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    btn_mode = 0; btn_next = 0; btn_up = 0; btn_down = 0;
    tick_1ms = 0; tick_1hz = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_set_mode", set_mode, 0);
    chk("rst_field", field_idx, 0);
    chk("rst_set_en", set_en, 0);
    chk("rst_pulses", {incr, decr}, 0);
    chk("rst_run_blink", {run_en, blink}, 0);
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_armed = 0; m_pm = 0; m_pn = 0; m_pu = 0; m_pd = 0; m_set = 0;
    m_field = 0; m_hold = 0; m_ticks = 0; m_secs = 0; m_ms = 0;
  endtask

  // One clock of the reference: rules expressed as press events, ticks held
  // since press, seconds idle and milliseconds spent in SET.
  task automatic model_step();
    bit pm, pn, pu, pd, nw, stay, act;
    pm = m_armed && btn_mode && !m_pm;
    pn = m_armed && btn_next && !m_pn;
    pu = m_armed && btn_up && !m_pu;
    pd = m_armed && btn_down && !m_pd;
    nw = m_set;
    if (pm) nw = !m_set;
    else if (m_set && m_secs >= TMO) nw = 0;
    stay = m_set && nw;
    if (!stay) m_field = 0;
    else if (pn) m_field = (m_field + 1) % NF;
    e_incr = 0; e_decr = 0;
    if (m_hold != 0) begin
      if (stay && !pn && (m_hold == 1 ? (btn_up && !btn_down) : (btn_down && !btn_up))) begin
        if (tick_1ms) begin
          m_ticks++;
          if (m_ticks >= DLY && (m_ticks - DLY) % RTE == 0) begin
            if (m_hold == 1) e_incr = 1; else e_decr = 1;
          end
        end
      end else m_hold = 0;
    end
    if (stay && pu && !btn_down) begin
      e_incr = 1;
      if (!pn) begin m_hold = 1; m_ticks = 0; end
    end else if (stay && pd && !btn_up) begin
      e_decr = 1;
      if (!pn) begin m_hold = 2; m_ticks = 0; end
    end
    act = pm || pn || pu || pd || btn_up || btn_down;
    if (!stay || act) m_secs = 0;
    else if (tick_1hz && m_secs < TMO) m_secs++;
    if (!stay) m_ms = 0;
    else if (tick_1ms) m_ms++;
    e_blink = stay && ((m_ms / BH) % 2 == 1);
    e_set = nw;
    e_run = tick_1hz && !nw;
    e_field = 3'(m_field);
    e_en = nw ? NF'(1 << m_field) : '0;
    m_set = nw;
    m_pm = btn_mode; m_pn = btn_next; m_pu = btn_up; m_pd = btn_down;
    m_armed = 1;
  endtask

  task automatic enter_set();
    btn_mode = 1; cyc();
    btn_mode = 0; cyc();
  endtask

  initial begin
    int pulses;
    logic [NF+7:0] act_v, exp_v;
    vecs[0]  = '{0,0,0,0,0,0, 0,3'd0,6'b000000, 0,0,0};
    vecs[1]  = '{0,0,0,0,0,1, 0,3'd0,6'b000000, 0,0,1};
    vecs[2]  = '{1,0,0,0,0,0, 1,3'd0,6'b000001, 0,0,0};
    vecs[3]  = '{0,0,0,0,0,1, 1,3'd0,6'b000001, 0,0,0};
    vecs[4]  = '{0,1,0,0,0,0, 1,3'd1,6'b000010, 0,0,0};
    vecs[5]  = '{0,0,0,0,0,0, 1,3'd1,6'b000010, 0,0,0};
    vecs[6]  = '{0,1,0,0,0,0, 1,3'd2,6'b000100, 0,0,0};
    vecs[7]  = '{0,0,0,0,0,0, 1,3'd2,6'b000100, 0,0,0};
    vecs[8]  = '{0,1,0,0,0,0, 1,3'd3,6'b001000, 0,0,0};
    vecs[9]  = '{0,0,0,0,0,0, 1,3'd3,6'b001000, 0,0,0};
    vecs[10] = '{0,0,1,0,0,0, 1,3'd3,6'b001000, 1,0,0};
    vecs[11] = '{0,0,0,0,0,0, 1,3'd3,6'b001000, 0,0,0};
    vecs[12] = '{1,0,1,0,0,0, 0,3'd0,6'b000000, 0,0,0};
    vecs[13] = '{0,0,0,0,0,0, 0,3'd0,6'b000000, 0,0,0};

    rst = 1'b1;
    clear_inputs();
    do_reset();
    foreach (vecs[i]) begin
      btn_mode = vecs[i].mode; btn_next = vecs[i].next;
      btn_up = vecs[i].up; btn_down = vecs[i].down;
      tick_1ms = vecs[i].t1ms; tick_1hz = vecs[i].t1hz;
      cyc();
      chk($sformatf("vec%0d_set_mode", i), set_mode, vecs[i].exp_set);
      chk($sformatf("vec%0d_field", i), field_idx, vecs[i].exp_field);
      chk($sformatf("vec%0d_set_en", i), set_en, vecs[i].exp_en);
      chk($sformatf("vec%0d_incr", i), incr, vecs[i].exp_incr);
      chk($sformatf("vec%0d_decr", i), decr, vecs[i].exp_decr);
      chk($sformatf("vec%0d_run_en", i), run_en, vecs[i].exp_run);
    end
    clear_inputs();

    // hold down for 800 ms: press pulse then pulses at 500, 600, 700, 800
    do_reset(); cyc();
    enter_set();
    btn_down = 1; cyc();
    chk("down_press_pulse", decr, 1);
    pulses = decr;
    for (int k = 1; k <= 800; k++) begin
      tick_1ms = 1; cyc();
      chk($sformatf("repeat_tick%0d", k), decr, (k >= DLY && (k - DLY) % RTE == 0) ? 1 : 0);
      pulses += decr + incr;
      tick_1ms = 0; cyc();
      pulses += decr + incr;
    end
    btn_down = 0;
    chk("repeat_total", pulses, 5);
    pulses = 0;
    for (int k = 0; k < 150; k++) begin
      tick_1ms = 1; cyc(); pulses += decr + incr;
    end
    tick_1ms = 0;
    chk("after_release_pulses", pulses, 0);

    // field wrap and up+down together
    do_reset(); cyc();
    enter_set();
    for (int k = 1; k <= 6; k++) begin
      btn_next = 1; cyc();
      btn_next = 0; cyc();
      if (k == 5) chk("field_last", field_idx, 5);
    end
    chk("field_wrap", field_idx, 0);
    chk("field_wrap_en", set_en, 1);
    btn_up = 1; btn_down = 1;
    pulses = 0;
    for (int k = 0; k < 1200; k++) begin
      tick_1ms = k[0]; cyc(); pulses += incr + decr;
    end
    chk("both_held_pulses", pulses, 0);
    clear_inputs(); cyc();

    // blink phase, then idle timeout back to RUN
    do_reset(); cyc();
    btn_mode = 1; cyc();
    btn_mode = 0; tick_1ms = 1;
    chk("blink_entry", blink, 0);
    for (int k = 1; k <= 500; k++) begin
      cyc();
      chk($sformatf("blink_k%0d", k), blink, (k / BH) % 2);
    end
    tick_1ms = 0;
    for (int s = 1; s <= TMO; s++) begin
      tick_1hz = 1; cyc();
      if (s == 1) chk("run_en_frozen", run_en, 0);
      tick_1hz = 0; cyc();
      if (s == TMO - 1) chk("timeout_not_yet", set_mode, 1);
    end
    chk("timeout_set_mode", set_mode, 0);
    chk("timeout_set_en", set_en, 0);
    tick_1hz = 1; cyc();
    chk("timeout_run_en", run_en, 1);
    tick_1hz = 0; cyc();
    chk("run_en_pulse", run_en, 0);

    // asynchronous reset mid-repeat, then buttons held across reset release
    do_reset(); cyc();
    enter_set();
    btn_next = 1; cyc(); btn_next = 0; cyc();
    btn_next = 1; cyc(); btn_next = 0; cyc();
    btn_up = 1; cyc();
    chk("up_press_pulse", incr, 1);
    for (int k = 1; k <= DLY; k++) begin
      tick_1ms = 1; cyc();
      if (k < DLY) begin tick_1ms = 0; cyc(); end
    end
    chk("pre_rst_incr", incr, 1);
    chk("pre_rst_field", field_idx, 2);
    rst = 1; #1;
    chk("async_rst_incr", incr, 0);
    chk("async_rst_set_mode", set_mode, 0);
    chk("async_rst_field", field_idx, 0);
    chk("async_rst_set_en", set_en, 0);
    chk("async_rst_other", {decr, run_en, blink}, 0);
    btn_mode = 1;
    repeat (3) cyc();
    rst = 0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick_1ms = k[0]; cyc(); pulses += incr + set_mode;
    end
    chk("held_at_reset_ignored", pulses, 0);
    btn_mode = 0; cyc();
    btn_mode = 1; cyc();
    chk("repress_mode", set_mode, 1);
    btn_mode = 0;
    pulses = 0;
    for (int k = 0; k < 700; k++) begin
      tick_1ms = 1; cyc(); pulses += incr;
    end
    chk("held_up_no_repeat", pulses, 0);
    clear_inputs(); cyc();

    // randomized stimulus against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 20000; n++) begin
      if (btn_up) btn_up = ($urandom_range(0, 299) != 0); else btn_up = ($urandom_range(0, 799) == 0);
      if (btn_down) btn_down = ($urandom_range(0, 299) != 0); else btn_down = ($urandom_range(0, 799) == 0);
      if (btn_next) btn_next = ($urandom_range(0, 2) != 0); else btn_next = ($urandom_range(0, 59) == 0);
      if (btn_mode) btn_mode = ($urandom_range(0, 3) != 0); else btn_mode = ($urandom_range(0, 1499) == 0);
      tick_1ms = ($urandom_range(0, 3) != 0);
      tick_1hz = ($urandom_range(0, 39) == 0);
      cyc();
      model_step();
      act_v = {set_mode, field_idx, set_en, incr, decr, run_en, blink};
      exp_v = {e_set, e_field, e_en, e_incr, e_decr, e_run, e_blink};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL random_cycle%0d actual=%h required=%h", n, act_v, exp_v);
        break;
      end
    end
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter NUM_FIELDS, default 6: number of editable BCD counter fields (index 0 = seconds ... 5 = year).
REQ-002 Parameter REPEAT_DELAY, default 500: tick_1ms ticks a button is held before auto-repeat starts.
REQ-003 Parameter REPEAT_RATE, default 100: tick_1ms ticks between auto-repeat pulses.
REQ-004 Parameter TIMEOUT, default 30: tick_1hz ticks without button activity before SET exits to RUN.
REQ-005 Parameter BLINK_HALF, default 250: tick_1ms ticks per blink half-period.
REQ-006 clk  input  1  single system clock; all state on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 tick_1ms  input  1  one-cycle strobe every 1 ms.
REQ-009 tick_1hz  input  1  one-cycle strobe every 1 s.
REQ-010 btn_mode, btn_next, btn_up, btn_down  input  1 each  debounced, clk-synchronous levels, active-high.
REQ-011 set_mode  output  1  1 = SET state, 0 = RUN state.
REQ-012 run_en  output  1  count_enable for the seconds counter.
REQ-013 field_idx  output  3  currently selected field.
REQ-014 set_en  output  NUM_FIELDS  one-hot set_enable per counter field.
REQ-015 incr, decr  output  1 each  one-cycle step pulses to the selected field.
REQ-016 blink  output  1  display blank strobe for the selected field.

Function
REQ-017 Press = rising edge of a button level (registered previous level vs. current); detected at cycle n, the registered response appears at cycle n+1.
REQ-018 Two-state FSM: RUN and SET; btn_mode press in RUN -> SET with field_idx = 0; btn_mode press in SET -> RUN.
REQ-019 run_en = tick_1hz registered, gated by RUN; it is 0 throughout SET (clock frozen while editing).
REQ-020 In SET, btn_next press: field_idx increments; NUM_FIELDS-1 wraps to 0. Ignored in RUN.
REQ-021 set_en = one-hot of field_idx in SET; all zero in RUN.
REQ-022 In SET, btn_up press -> incr high exactly one cycle; btn_down press -> decr high exactly one cycle; incr and decr never both 1.
REQ-023 Auto-repeat: while the same up/down button stays held, after REPEAT_DELAY tick_1ms ticks from the press emit one pulse, then one pulse every REPEAT_RATE ticks until release.
REQ-024 Repeat sub-FSM states IDLE, DELAY, REPEAT; release, state change or btn_next/btn_mode press returns it to IDLE and clears its counter.
REQ-025 btn_up and btn_down both high: no pulses, repeat sub-FSM held in IDLE until both released.
REQ-026 Simultaneous btn_mode press with up/down/next press: mode transition wins, other events dropped in that cycle.
REQ-027 Timeout counter clears on any press or held up/down; counts tick_1hz in SET; reaching TIMEOUT -> RUN next cycle, counter cleared.
REQ-028 blink toggles every BLINK_HALF tick_1ms ticks in SET, starts at 0 on entering SET; forced 0 in RUN.
REQ-029 All outputs registered; no combinational path input -> output.
REQ-030 All counters wide enough for their parameter; no wrap before terminal count.

Reset
REQ-031 rst high asynchronously forces: RUN, field_idx=0, set_en=0, incr=0, decr=0, run_en=0, blink=0, set_mode=0, repeat IDLE, all counters 0, button history = 0.
REQ-032 Buttons held at reset release are not seen as presses until released and pressed again (history loads current level on first cycle after reset).
REQ-033 Reset asserted mid-repeat or mid-SET aborts without emitting further pulses.

Verification
REQ-034 Mode press, 3 next presses, 1 up press -> set_mode=1, field_idx=3, set_en=6'b001000, single incr pulse one cycle after edge.
REQ-035 Hold btn_down 800 tick_1ms -> decr at press, at tick 500, at tick 600, 700, 800 (5 pulses total).
REQ-036 In SET, 6 next presses from field 0 -> field_idx returns to 0; up+down together -> zero pulses.
REQ-037 Enter SET, no buttons for 30 tick_1hz -> set_mode=0, set_en=0, run_en follows tick_1hz next second.
REQ-038 Mode and up pressed same cycle in SET -> RUN, no incr; rst pulse during repeat -> all outputs 0 immediately.
